// File: rtl/cdwu_pkg.sv
// cdwu_pkg: shared constants and helpers for the cdwu_rr write-conflict resolver
package cdwu_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/cdwu_arb.sv
// cdwu_arb: combinational one-hot winner select, fixed priority with aging or round-robin
//   req_i : pending channels
//   pri_i : aged (promoted) channels, subset of req_i, ignored in round-robin mode
//   ptr_i : round-robin start index, ignored in fixed mode
//   win_o : one-hot winner, all-zero when nothing is pending
//   idx_o : index of the winner, 0 when nothing is pending
module cdwu_arb import cdwu_pkg::*; #(
  parameter int NCH  = 3,
  parameter int MODE = MODE_FIXED,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [NCH-1:0]  pri_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [NCH-1:0]  win_o,
  output logic [SELW-1:0] idx_o
);
  logic [NCH-1:0] cand;
  int base;
  int j;
  // fixed mode searches from 0 over the aged set if any, else over all pending
  assign cand = (MODE == MODE_RR) ? req_i : (|pri_i ? pri_i : req_i);
  assign base = (MODE == MODE_RR) ? int'(ptr_i) : 0;
  // walk the search order backwards so the earliest candidate is written last
  always_comb begin
    win_o = '0;
    idx_o = '0;
    j = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = (base + i) % NCH;
      if (cand[j]) begin
        win_o = '0;
        win_o[j] = 1'b1;
        idx_o = SELW'(j);
      end
    end
  end
endmodule

// File: rtl/cdwu_rr.sv
// cdwu_rr: registered multi-channel write-conflict resolver for the banked write port
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : per-channel request handshake (in_ready low during reset)
//   in_addr/in_data    : packed per-channel address and data
//   o_en/o_addr/o_data : registered write port
//   o_sel              : registered index of the issued channel
module cdwu_rr import cdwu_pkg::*; #(
  parameter int NCH      = 3,
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int DATABITS = 64,
  parameter int MODE     = MODE_FIXED,
  parameter int AGELIMIT = 4,
  localparam int A       = BANKBITS + WORDBITS,
  localparam int SELW    = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          in_valid,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH*A-1:0]        in_addr,
  input  logic [NCH*DATABITS-1:0] in_data,
  output logic                    o_en,
  output logic [A-1:0]            o_addr,
  output logic [DATABITS-1:0]     o_data,
  output logic [SELW-1:0]         o_sel
);
  localparam int AW = (clog2(AGELIMIT + 1) > 1) ? clog2(AGELIMIT + 1) : 1;
  localparam logic [AW-1:0] AGEMAX = AW'(AGELIMIT);
  localparam bit AGING = (MODE == MODE_FIXED) && (AGELIMIT != 0);
  logic [NCH-1:0]      pend_q, pend_d, acc, pri, win;
  logic [SELW-1:0]     idx, ptr_q, ptr_d, sel_q, sel_d;
  logic [A-1:0]        hold_addr_q [NCH];
  logic [DATABITS-1:0] hold_data_q [NCH];
  logic [AW-1:0]       age_q [NCH];
  logic [AW-1:0]       age_d [NCH];
  logic                en_q, en_d, any_win;
  logic [A-1:0]        addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;
  cdwu_arb #(.NCH(NCH), .MODE(MODE), .SELW(SELW)) u_arb (
    .req_i (pend_q),
    .pri_i (pri),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (idx)
  );
  // a winning channel may refill in the same cycle its entry leaves
  assign in_ready = rst_n ? (~pend_q | win) : '0;
  assign acc      = in_valid & in_ready;
  assign pend_d   = acc | (pend_q & ~win);
  assign any_win  = |win;
  assign en_d     = any_win;
  assign addr_d   = any_win ? hold_addr_q[idx] : addr_q;
  assign data_d   = any_win ? hold_data_q[idx] : data_q;
  assign sel_d    = any_win ? idx : sel_q;
  assign ptr_d    = (MODE == MODE_RR && any_win) ? ((idx == SELW'(NCH - 1)) ? '0 : idx + 1'b1) : ptr_q;
  always_comb begin
    for (int k = 0; k < NCH; k++) pri[k] = AGING && pend_q[k] && (age_q[k] == AGEMAX);
  end
  // age only counts consecutive denials of a pending entry, saturating at the limit
  always_comb begin
    for (int k = 0; k < NCH; k++)
      age_d[k] = (!AGING || !pend_q[k] || win[k]) ? '0 : ((age_q[k] == AGEMAX) ? age_q[k] : age_q[k] + 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      age_q  <= '{default: '0};
      ptr_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      pend_q <= pend_d;
      age_q  <= age_d;
      ptr_q  <= ptr_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end
  // payload needs no reset: it is only observed while pend_q is set
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (acc[k]) begin
        hold_addr_q[k] <= in_addr[k*A +: A];
        hold_data_q[k] <= in_data[k*DATABITS +: DATABITS];
      end
    end
  end
  assign o_en   = en_q;
  assign o_addr = addr_q;
  assign o_data = data_q;
  assign o_sel  = sel_q;
endmodule

// File: tb/tb_cdwu_rr.sv
// tb_cdwu_rr: directed self-checking bench for cdwu_rr in fixed and round-robin modes
module tb_cdwu_rr;
  import cdwu_pkg::*;
  localparam int NCH = 3;
  localparam int A   = 14;
  localparam int DW  = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH*A-1:0] in_addr = '0;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0] rdy_f, rdy_r;
  logic en_f, en_r;
  logic [A-1:0] addr_f, addr_r;
  logic [DW-1:0] data_f, data_r;
  logic [1:0] sel_f, sel_r;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cdwu_rr #(.MODE(MODE_FIXED)) u_fix (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f),
    .in_addr(in_addr), .in_data(in_data),
    .o_en(en_f), .o_addr(addr_f), .o_data(data_f), .o_sel(sel_f)
  );
  cdwu_rr #(.MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_r),
    .in_addr(in_addr), .in_data(in_data),
    .o_en(en_r), .o_addr(addr_r), .o_data(data_r), .o_sel(sel_r)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int k, input logic [A-1:0] a, input logic [DW-1:0] d);
    in_addr[k*A +: A] = a;
    in_data[k*DW +: DW] = d;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask
  logic [1:0]  fsel [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
  logic [63:0] fdat [10] = '{64'hD0, 64'hD0, 64'hD0, 64'hD0, 64'hD2, 64'hD0, 64'hE0, 64'hE0, 64'hE0, 64'hD2};
  initial begin
    // reset state, in_ready forced low even with requests present
    in_valid = 3'b111;
    step();
    check("rst_en", en_f, 0);
    check("rst_addr", addr_f, 0);
    check("rst_data", data_f, 0);
    check("rst_sel", sel_f, 0);
    check("rst_rdy_f", rdy_f, 0);
    check("rst_rdy_r", rdy_r, 0);
    // single write latency
    in_valid = '0;
    rst_n = 1'b1;
    set_ch(1, 14'h0123, 64'hA5);
    in_valid = 3'b010;
    step();
    in_valid = '0;
    check("lat_e0_en", en_f, 0);
    step();
    check("lat_e1_en", en_f, 1);
    check("lat_e1_addr", addr_f, 14'h0123);
    check("lat_e1_data", data_f, 64'hA5);
    check("lat_e1_sel", sel_f, 1);
    step();
    check("lat_e2_en", en_f, 0);
    check("lat_e2_addr_hold", addr_f, 14'h0123);
    // fixed aging with ch0/ch2 continuous, plus back-pressure on ch0
    do_reset();
    set_ch(0, 14'h0011, 64'hD0);
    set_ch(2, 14'h0222, 64'hD2);
    in_valid = 3'b101;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("age_en", en_f, 1);
      check("age_sel", sel_f, fsel[i]);
      check("age_data", data_f, fdat[i]);
      if (i == 3) begin
        check("bp_rdy0", rdy_f[0], 0);
        check("bp_rdy2", rdy_f[2], 1);
        set_ch(0, 14'h0011, 64'hE0);
      end
    end
    // round-robin order with all channels continuous
    do_reset();
    set_ch(0, 14'h0100, 64'hC0);
    set_ch(1, 14'h0101, 64'hC1);
    set_ch(2, 14'h0102, 64'hC2);
    in_valid = 3'b111;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_en", en_r, 1);
      check("rr_sel", sel_r, i % 3);
      check("rr_addr", addr_r, 14'h0100 + (i % 3));
    end
    // same-edge issue and refill on ch1
    do_reset();
    set_ch(1, 14'h0155, 64'hB1);
    in_valid = 3'b010;
    step();
    check("refill_rdy1", rdy_f[1], 1);
    set_ch(1, 14'h0156, 64'hB2);
    step();
    in_valid = '0;
    check("refill_e1_en", en_f, 1);
    check("refill_e1_data", data_f, 64'hB1);
    check("refill_e1_addr", addr_f, 14'h0155);
    step();
    check("refill_e2_en", en_f, 1);
    check("refill_e2_data", data_f, 64'hB2);
    check("refill_e2_addr", addr_f, 14'h0156);
    step();
    check("refill_e3_en", en_f, 0);
    // asynchronous reset while entries are pending
    do_reset();
    set_ch(0, 14'h0301, 64'hF0);
    set_ch(1, 14'h0302, 64'hF1);
    set_ch(2, 14'h0303, 64'hF2);
    in_valid = 3'b111;
    step();
    step();
    in_valid = '0;
    check("mid_pre_en", en_f, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_en_f", en_f, 0);
    check("mid_addr_f", addr_f, 0);
    check("mid_data_f", data_f, 0);
    check("mid_sel_f", sel_f, 0);
    check("mid_rdy_f", rdy_f, 0);
    check("mid_en_r", en_r, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_en_f", en_f, 0);
      check("post_en_r", en_r, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
